// File: rtl/magnitude_peak_detector_pkg.sv
// ============================================================================
// Module   : magnitude_peak_detector_pkg
// Brief    : Shared state encoding and default widths for the peak detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package magnitude_peak_detector_pkg;

  // Default magnitude width shared with the upstream magnitude stage.
  localparam int c_DEFAULT_DATA_WIDTH = 83;

  localparam int c_STATE_WIDTH = 2;
  typedef logic [c_STATE_WIDTH-1:0] state_t;

  localparam state_t c_IDLE   = 2'd0;
  localparam state_t c_SCAN   = 2'd1;
  localparam state_t c_REPORT = 2'd2;

  // True when an index/counter of indexWidth bits can address every sample.
  function automatic bit index_width_ok(input int indexWidth, input int windowLength);
    longint span;
    span = longint'(1) << indexWidth;
    return span >= longint'(windowLength);
  endfunction

endpackage

`default_nettype wire

// File: rtl/magnitude_peak_detector_if.sv
// ============================================================================
// Module   : magnitude_peak_detector_if
// Brief    : Sample stream, control handshake and report bundle of the detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface magnitude_peak_detector_if
  import magnitude_peak_detector_pkg::*;
#(
  parameter int DATA_WIDTH  = c_DEFAULT_DATA_WIDTH,
  parameter int INDEX_WIDTH = 10
);

  logic                   enable;
  logic                   start;
  logic                   dataInValid;
  logic [DATA_WIDTH-1:0]  dataIn;
  logic [DATA_WIDTH-1:0]  threshold;

  logic                   busy;
  logic                   peakValid;
  logic [DATA_WIDTH-1:0]  peakValue;
  logic [INDEX_WIDTH-1:0] peakIndex;
  logic                   peakFound;

  // Controller / magnitude-stage side.
  modport master (
    output enable, start, dataInValid, dataIn, threshold,
    input  busy, peakValid, peakValue, peakIndex, peakFound
  );

  // Detector side.
  modport slave (
    input  enable, start, dataInValid, dataIn, threshold,
    output busy, peakValid, peakValue, peakIndex, peakFound
  );

endinterface

`default_nettype wire

// File: rtl/magnitude_peak_detector_peak_tracker.sv
// ============================================================================
// Module   : magnitude_peak_detector_peak_tracker
// Brief    : Running maximum and its index; first sample always loads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module magnitude_peak_detector_peak_tracker
  import magnitude_peak_detector_pkg::*;
#(
  parameter int DATA_WIDTH  = c_DEFAULT_DATA_WIDTH,
  parameter int INDEX_WIDTH = 10
) (
  input  wire logic                   clock,
  input  wire logic                   reset,
  input  wire logic                   clear,
  input  wire logic                   sampleValid,
  input  wire logic                   firstSample,
  input  wire logic [DATA_WIDTH-1:0]  sample,
  input  wire logic [INDEX_WIDTH-1:0] sampleIndex,
  output logic      [DATA_WIDTH-1:0]  nextMax,
  output logic      [INDEX_WIDTH-1:0] nextIndex
);

  logic [DATA_WIDTH-1:0]  r_runningMax;
  logic [INDEX_WIDTH-1:0] r_runningIndex;
  logic                   w_load;

  // Strict greater-than so a tie keeps the earliest index.
  assign w_load    = sampleValid && (firstSample || (sample > r_runningMax));
  assign nextMax   = w_load ? sample      : r_runningMax;
  assign nextIndex = w_load ? sampleIndex : r_runningIndex;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_runningMax   <= '0;
      r_runningIndex <= '0;
    end else if (w_load) begin
      r_runningMax   <= sample;
      r_runningIndex <= sampleIndex;
    end
  end

endmodule

`default_nettype wire

// File: rtl/magnitude_peak_detector.sv
// ============================================================================
// Module   : magnitude_peak_detector
// Brief    : Per-window peak magnitude/index search with threshold flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module magnitude_peak_detector
  import magnitude_peak_detector_pkg::*;
#(
  parameter int DATA_WIDTH    = c_DEFAULT_DATA_WIDTH,
  parameter int WINDOW_LENGTH = 800,
  parameter int INDEX_WIDTH   = 10
) (
  input wire logic                  clock,
  input wire logic                  reset,
  magnitude_peak_detector_if.slave  bus
);

  generate
    if (WINDOW_LENGTH < 2 || !index_width_ok(INDEX_WIDTH, WINDOW_LENGTH)) begin : g_param_check
      $error("magnitude_peak_detector: need WINDOW_LENGTH >= 2 and 2**INDEX_WIDTH >= WINDOW_LENGTH");
    end
  endgenerate

  localparam logic [INDEX_WIDTH-1:0] c_LAST_INDEX = INDEX_WIDTH'(WINDOW_LENGTH - 1);

  state_t                 r_state;
  state_t                 w_nextState;
  logic [INDEX_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0]  r_threshold;
  logic [DATA_WIDTH-1:0]  r_peakValue;
  logic [INDEX_WIDTH-1:0] r_peakIndex;
  logic                   r_peakFound;

  logic                   w_startWindow;
  logic                   w_accept;
  logic                   w_lastSample;
  logic                   w_busy;
  logic                   w_peakValid;
  logic [DATA_WIDTH-1:0]  w_nextMax;
  logic [INDEX_WIDTH-1:0] w_nextIndex;

  assign w_startWindow = bus.enable && bus.start && (r_state == c_IDLE);
  assign w_accept      = bus.enable && bus.dataInValid && (r_state == c_SCAN);
  assign w_lastSample  = w_accept && (r_count == c_LAST_INDEX);

  magnitude_peak_detector_peak_tracker #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_peak_tracker (
    .clock       (clock),
    .reset       (reset),
    .clear       (w_startWindow),
    .sampleValid (w_accept),
    .firstSample (r_count == '0),
    .sample      (bus.dataIn),
    .sampleIndex (r_count),
    .nextMax     (w_nextMax),
    .nextIndex   (w_nextIndex)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else if (bus.enable) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:   if (bus.start) w_nextState = c_SCAN;
      c_SCAN:   if (bus.dataInValid && (r_count == c_LAST_INDEX)) w_nextState = c_REPORT;
      c_REPORT: w_nextState = c_IDLE;
      default:  w_nextState = c_IDLE;
    endcase
  end

  // The pulse is withheld while stalled; REPORT persists, so it reappears on resume.
  always_comb begin
    w_busy      = (r_state == c_SCAN);
    w_peakValid = (r_state == c_REPORT) && bus.enable;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_threshold <= '0;
    end else if (w_startWindow) begin
      r_count     <= '0;
      r_threshold <= bus.threshold;
    end else if (w_accept) begin
      r_count     <= r_count + 1'b1;
    end
  end

  // Report registers load on the edge that enters REPORT, so they are already
  // stable during the cycle in which peakValid is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_peakValue <= '0;
      r_peakIndex <= '0;
      r_peakFound <= 1'b0;
    end else if (w_lastSample) begin
      r_peakValue <= w_nextMax;
      r_peakIndex <= w_nextIndex;
      r_peakFound <= (w_nextMax >= r_threshold);
    end
  end

  assign bus.busy      = w_busy;
  assign bus.peakValid = w_peakValid;
  assign bus.peakValue = r_peakValue;
  assign bus.peakIndex = r_peakIndex;
  assign bus.peakFound = r_peakFound;

endmodule

`default_nettype wire

// File: tb/tb_magnitude_peak_detector.sv
// ============================================================================
// Module   : tb_magnitude_peak_detector
// Brief    : Randomized scoreboard bench for magnitude_peak_detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_magnitude_peak_detector;

  localparam int DW = 83;
  localparam int WL = 8;
  localparam int IW = 3;

  typedef struct {
    logic [DW-1:0] value;
    logic [IW-1:0] index;
    logic          found;
    int            cyc;
    int            busyCycles;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   nChecks = 0;
  int   nFail = 0;
  int   busyCnt = 0;

  exp_t          q[$];
  exp_t          lastExp;
  logic [DW-1:0] win[WL];
  int            gapInv[WL];
  int            gapStall[WL];

  magnitude_peak_detector_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

  magnitude_peak_detector #(
    .DATA_WIDTH    (DW),
    .WINDOW_LENGTH (WL),
    .INDEX_WIDTH   (IW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: first occurrence of the largest value in the window.
  function automatic exp_t model(input logic [DW-1:0] thr);
    exp_t e;
    logic [DW-1:0] mx;
    int ix;
    mx = win[0];
    ix = 0;
    for (int i = 1; i < WL; i++) begin
      if (win[i] > mx) begin
        mx = win[i];
        ix = i;
      end
    end
    e.value = mx;
    e.index = IW'(ix);
    e.found = (mx >= thr);
    e.cyc = 0;
    e.busyCycles = 0;
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd_sample(input int mode);
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    if (mode == 0) return DW'($urandom_range(0, 7));
    return w[DW-1:0];
  endfunction

  task automatic clear_gaps();
    for (int i = 0; i < WL; i++) begin
      gapInv[i] = 0;
      gapStall[i] = 0;
    end
  endtask

  task automatic do_window(input logic [DW-1:0] thr, input bit startNoise, input int reportStall);
    exp_t e;
    int scan;
    int lastCyc;
    scan = 0;
    bus.enable = 1'b1;
    bus.start = 1'b1;
    bus.threshold = thr;
    bus.dataInValid = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.threshold = ~thr;
    for (int i = 0; i < WL; i++) begin
      repeat (gapInv[i]) begin
        bus.enable = 1'b1;
        bus.dataInValid = 1'b0;
        bus.dataIn = '1;
        bus.start = startNoise;
        tick();
        scan++;
      end
      repeat (gapStall[i]) begin
        bus.enable = 1'b0;
        bus.dataInValid = 1'b1;
        bus.dataIn = '1;
        bus.start = startNoise;
        tick();
        scan++;
      end
      bus.enable = 1'b1;
      bus.dataInValid = 1'b1;
      bus.dataIn = win[i];
      bus.start = startNoise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      scan++;
    end
    lastCyc = cyc;
    e = model(thr);
    e.cyc = lastCyc + reportStall;
    e.busyCycles = scan;
    q.push_back(e);
    lastExp = e;
    repeat (reportStall) begin
      bus.enable = 1'b0;
      bus.dataInValid = 1'b1;
      bus.dataIn = '1;
      bus.start = startNoise;
      tick();
    end
    bus.enable = 1'b1;
    bus.start = startNoise;
    bus.dataInValid = startNoise;
    bus.dataIn = '1;
    tick();
    bus.start = 1'b0;
    bus.dataInValid = 1'b0;
    if (startNoise) chk("start in REPORT ignored (busy)", DW'(bus.busy), '0);
  endtask

  // Monitor: pops the scoreboard on every peakValid pulse.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      busyCnt = 0;
    end else begin
      if (bus.busy) busyCnt++;
      if (bus.peakValid) begin
        if (q.size() == 0) begin
          chk("unexpected peakValid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("peakValue", bus.peakValue, e.value);
          chk("peakIndex", DW'(bus.peakIndex), DW'(e.index));
          chk("peakFound", DW'(bus.peakFound), DW'(e.found));
          chk("peakValid cycle", DW'(cyc), DW'(e.cyc));
          chk("busy cycles", DW'(busyCnt), DW'(e.busyCycles));
        end
        busyCnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pat[WL];
    logic [DW-1:0] thr;
    bus.enable = 1'b0;
    bus.start = 1'b0;
    bus.dataInValid = 1'b0;
    bus.dataIn = '0;
    bus.threshold = '0;
    clear_gaps();
    repeat (3) tick();
    reset = 1'b0;
    chk("reset busy", DW'(bus.busy), '0);
    chk("reset peakValid", DW'(bus.peakValid), '0);
    chk("reset peakValue", bus.peakValue, '0);
    chk("reset peakIndex", DW'(bus.peakIndex), '0);
    chk("reset peakFound", DW'(bus.peakFound), '0);

    pat = '{3, 9, 4, 60, 12, 60, 1, 7};
    for (int i = 0; i < WL; i++) win[i] = DW'(pat[i]);
    do_window(DW'(50), 1'b0, 0);
    tick();
    do_window(DW'(61), 1'b0, 0);
    tick();
    for (int i = 0; i < WL; i++) win[i] = '0;
    do_window('0, 1'b0, 0);
    tick();

    // Same data with invalid gaps and enable stalls mid-window.
    for (int i = 0; i < WL; i++) win[i] = DW'(pat[i]);
    win[0] = DW'(5);
    gapInv[3] = 3;
    gapStall[5] = 2;
    do_window(DW'(50), 1'b0, 2);
    clear_gaps();
    repeat (3) tick();
    chk("report hold peakValue", bus.peakValue, lastExp.value);
    chk("report hold peakIndex", DW'(bus.peakIndex), DW'(lastExp.index));

    // Abort a window with reset after 4 samples.
    bus.start = 1'b1;
    bus.threshold = DW'(1);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.dataInValid = 1'b1;
      bus.dataIn = DW'(100 + i);
      tick();
    end
    bus.dataInValid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset busy", DW'(bus.busy), '0);
    chk("midreset peakValid", DW'(bus.peakValid), '0);
    chk("midreset peakValue", bus.peakValue, '0);
    chk("midreset peakIndex", DW'(bus.peakIndex), '0);
    chk("midreset peakFound", DW'(bus.peakFound), '0);
    for (int i = 0; i < WL; i++) win[i] = rnd_sample(1) >> 1;
    win[WL-1] = '1;
    do_window(rnd_sample(1), 1'b0, 0);
    tick();

    // Start pulses during SCAN and REPORT must be ignored.
    for (int i = 0; i < WL; i++) win[i] = rnd_sample(0);
    do_window(DW'(4), 1'b1, 1);
    repeat (2) begin
      tick();
      chk("idle after ignored start", DW'(bus.busy), '0);
    end
    chk("hold until next window", bus.peakValue, lastExp.value);

    for (int w = 0; w < 20; w++) begin
      int mode;
      mode = $urandom_range(0, 1);
      for (int i = 0; i < WL; i++) begin
        win[i] = rnd_sample(mode);
        gapInv[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        gapStall[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      case ($urandom_range(0, 2))
        0: thr = win[$urandom_range(0, WL-1)];
        1: thr = model('0).value;
        default: thr = rnd_sample(mode);
      endcase
      do_window(thr, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) tick();
    end
    clear_gaps();

    repeat (4) tick();
    chk("scoreboard drained", DW'(q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

`default_nettype wire
